// File: rtl/regfile_master.sv
// rtl/regfile_master.sv - command-driven initiator for the 16x32 register file
// Optional CLEAR sweep enabled by REGFILE_MASTER_CLEAR_EN.
module regfile_master (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_dst,
    input  logic [3:0]  cmd_src,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] rf_ip,
    output logic [3:0]  rf_sel_i,
    output logic [3:0]  rf_sel_o1,
    output logic [3:0]  rf_sel_o2,
    output logic        rf_wr,
    output logic        rf_rd,
    output logic        rf_en,
    input  logic [31:0] rf_op1,
    input  logic [31:0] rf_op2
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_CAP  = 3'd3,
        S_CPWR = 3'd4,
`ifdef REGFILE_MASTER_CLEAR_EN
        S_CLR  = 3'd5,
`endif
        S_RSP  = 3'd6
    } state_t;

    state_t      r_state;
    logic [1:0]  r_op;
    logic [3:0]  r_dst;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;
    logic [31:0] r_rf_ip;
    logic [3:0]  r_rf_sel_i;
    logic [3:0]  r_rf_sel_o1;
    logic [3:0]  r_rf_sel_o2;
    logic        r_rf_wr;
    logic        r_rf_rd;
    logic        r_rf_en;
`ifdef REGFILE_MASTER_CLEAR_EN
    logic [3:0]  r_cnt;
`endif

    // Op2 is reserved on this port; both read selects track the source.
    logic w_unused_op2;
    assign w_unused_op2 = ^rf_op2;

    // Strobes for the next cycle are set on the edge that enters a state,
    // so every register file access lines up with its state's cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= 2'b00;
            r_dst       <= 4'd0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_rf_ip     <= 32'h0;
            r_rf_sel_i  <= 4'd0;
            r_rf_sel_o1 <= 4'd0;
            r_rf_sel_o2 <= 4'd0;
            r_rf_wr     <= 1'b0;
            r_rf_rd     <= 1'b0;
            r_rf_en     <= 1'b0;
`ifdef REGFILE_MASTER_CLEAR_EN
            r_cnt       <= 4'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_cmd_ready) begin
                        r_cmd_ready <= 1'b1;
                    end else if (cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_op        <= cmd_op;
                        r_dst       <= cmd_dst;
                        case (cmd_op)
                            OP_WRITE: begin
                                r_rf_en    <= 1'b1;
                                r_rf_wr    <= 1'b1;
                                r_rf_sel_i <= cmd_dst;
                                r_rf_ip    <= cmd_data;
                                r_state    <= S_WR;
                            end
                            OP_READ, OP_COPY: begin
                                r_rf_en     <= 1'b1;
                                r_rf_rd     <= 1'b1;
                                r_rf_sel_o1 <= cmd_src;
                                r_rf_sel_o2 <= cmd_src;
                                r_state     <= S_RD;
                            end
                            default: begin
`ifdef REGFILE_MASTER_CLEAR_EN
                                r_rf_en    <= 1'b1;
                                r_rf_wr    <= 1'b1;
                                r_rf_sel_i <= 4'd0;
                                r_rf_ip    <= 32'h0;
                                r_cnt      <= 4'd0;
                                r_state    <= S_CLR;
`else
                                r_rsp_valid <= 1'b1;
                                r_rsp_data  <= 32'h0;
                                r_rsp_err   <= 1'b1;
                                r_state     <= S_RSP;
`endif
                            end
                        endcase
                    end
                end
                S_WR, S_CPWR: begin
                    r_rf_en     <= 1'b0;
                    r_rf_wr     <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= 32'h0;
                    r_rsp_err   <= 1'b0;
                    r_state     <= S_RSP;
                end
                S_RD: begin
                    r_rf_en <= 1'b0;
                    r_rf_rd <= 1'b0;
                    r_state <= S_CAP;
                end
                S_CAP: begin
                    // The captured word lands directly in the register that
                    // will carry it next: write data for COPY, response for READ.
                    if (r_op == OP_COPY) begin
                        r_rf_en    <= 1'b1;
                        r_rf_wr    <= 1'b1;
                        r_rf_sel_i <= r_dst;
                        r_rf_ip    <= rf_op1;
                        r_state    <= S_CPWR;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= rf_op1;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_RSP;
                    end
                end
`ifdef REGFILE_MASTER_CLEAR_EN
                S_CLR: begin
                    if (r_cnt == 4'd15) begin
                        r_rf_en     <= 1'b0;
                        r_rf_wr     <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= 32'h0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_RSP;
                    end else begin
                        r_cnt      <= r_cnt + 4'd1;
                        r_rf_sel_i <= r_cnt + 4'd1;
                    end
                end
`endif
                S_RSP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_data  <= 32'h0;
                    r_rsp_err   <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign rf_ip     = r_rf_ip;
    assign rf_sel_i  = r_rf_sel_i;
    assign rf_sel_o1 = r_rf_sel_o1;
    assign rf_sel_o2 = r_rf_sel_o2;
    assign rf_wr     = r_rf_wr;
    assign rf_rd     = r_rf_rd;
    assign rf_en     = r_rf_en;

endmodule

// File: tb/tb_regfile_master.sv
// tb/tb_regfile_master.sv - directed self-checking bench for regfile_master
// Covers both builds of REGFILE_MASTER_CLEAR_EN.
module tb_regfile_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_dst;
    logic [3:0]  cmd_src;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] rf_ip;
    logic [3:0]  rf_sel_i;
    logic [3:0]  rf_sel_o1;
    logic [3:0]  rf_sel_o2;
    logic        rf_wr;
    logic        rf_rd;
    logic        rf_en;
    logic [31:0] rf_op1;
    logic [31:0] rf_op2;

    int n_checks;
    int n_fail;

    int          o_rsp_k;
    logic [31:0] o_rsp_data;
    logic        o_rsp_err;
    int          o_wr_cnt;
    int          o_rd_cnt;
    int          o_en_cnt;
    logic        o_ready_busy;
    logic        o_ready_after;
    logic        o_both;
    logic [3:0]  sel_log [16];

    logic [31:0] mem [16];

    regfile_master dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_src   (cmd_src),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .rf_ip     (rf_ip),
        .rf_sel_i  (rf_sel_i),
        .rf_sel_o1 (rf_sel_o1),
        .rf_sel_o2 (rf_sel_o2),
        .rf_wr     (rf_wr),
        .rf_rd     (rf_rd),
        .rf_en     (rf_en),
        .rf_op1    (rf_op1),
        .rf_op2    (rf_op2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: synchronous write, registered read ports.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h5a5a_0000 + i;
        rf_op1 = 32'h0;
        rf_op2 = 32'h0;
    end
    always @(posedge clk) begin
        if (rf_en && rf_wr) mem[rf_sel_i] <= rf_ip;
        if (rf_en && rf_rd) begin
            rf_op1 <= mem[rf_sel_o1];
            rf_op2 <= mem[rf_sel_o2];
        end
    end

    task automatic run_cmd(input logic [1:0] op, input logic [3:0] dst,
                           input logic [3:0] src, input logic [31:0] data);
        int wait_cnt;
        o_rsp_k = -1; o_rsp_data = 32'hx; o_rsp_err = 1'bx;
        o_wr_cnt = 0; o_rd_cnt = 0; o_en_cnt = 0;
        o_ready_busy = 1'b0; o_ready_after = 1'b0; o_both = 1'b0;
        wait_cnt = 0;
        while (!cmd_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (!cmd_ready) begin
            n_checks++; n_fail++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%0b required 1", cmd_ready);
            return;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_data = data;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (rf_en) o_en_cnt++;
            if (rf_en && rf_rd) o_rd_cnt++;
            if (rf_en && rf_wr) begin
                if (o_wr_cnt < 16) sel_log[o_wr_cnt] = rf_sel_i;
                o_wr_cnt++;
            end
            if (rf_wr && rf_rd) o_both = 1'b1;
            if (cmd_ready) o_ready_busy = 1'b1;
            if (rsp_valid) begin
                o_rsp_k = k; o_rsp_data = rsp_data; o_rsp_err = rsp_err;
                break;
            end
        end
        @(negedge clk);
        o_ready_after = cmd_ready;
        if (rsp_valid) o_rsp_k = -2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({cmd_ready, rsp_valid, rsp_err, rf_wr, rf_rd, rf_en} !== 6'b0 ||
            rsp_data !== 32'h0 || rf_ip !== 32'h0 ||
            {rf_sel_i, rf_sel_o1, rf_sel_o2} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%0b rsp_v=%0b data=%h ip=%h en=%0b required all 0",
                     cmd_ready, rsp_valid, rsp_data, rf_ip, rf_en);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready_at_release: got %0b required 0", cmd_ready);
        end
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready_after_edge: got %0b required 1", cmd_ready);
        end
    endtask

    task automatic test_write_read();
        run_cmd(2'b00, 4'd0, 4'd0, 32'habcd_efab);
        n_checks++;
        if (o_rsp_k !== 2 || o_rsp_data !== 32'h0 || o_rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL write_rsp: k=%0d data=%h err=%b required k=2 data=0 err=0",
                     o_rsp_k, o_rsp_data, o_rsp_err);
        end
        n_checks++;
        if (o_wr_cnt !== 1 || o_en_cnt !== 1 || sel_log[0] !== 4'd0) begin
            n_fail++;
            $display("FAIL write_strobe: wr=%0d en=%0d sel=%0d required 1 1 0",
                     o_wr_cnt, o_en_cnt, sel_log[0]);
        end
        n_checks++;
        if (o_ready_busy !== 1'b0 || o_ready_after !== 1'b1) begin
            n_fail++;
            $display("FAIL write_ready: busy=%b after=%b required 0 1", o_ready_busy, o_ready_after);
        end
        run_cmd(2'b01, 4'd0, 4'd0, 32'h0);
        n_checks++;
        if (o_rsp_k !== 3 || o_rsp_data !== 32'habcd_efab || o_rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL read_rsp: k=%0d data=%h err=%b required k=3 data=abcdefab err=0",
                     o_rsp_k, o_rsp_data, o_rsp_err);
        end
        n_checks++;
        if (o_rd_cnt !== 1 || o_wr_cnt !== 0 || o_both !== 1'b0) begin
            n_fail++;
            $display("FAIL read_strobe: rd=%0d wr=%0d both=%b required 1 0 0",
                     o_rd_cnt, o_wr_cnt, o_both);
        end
    endtask

    task automatic test_copy();
        run_cmd(2'b00, 4'd1, 4'd0, 32'h0123_4567);
        run_cmd(2'b10, 4'd5, 4'd1, 32'h0);
        n_checks++;
        if (o_rsp_k !== 4 || o_rsp_data !== 32'h0 || o_rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL copy_rsp: k=%0d data=%h err=%b required k=4 data=0 err=0",
                     o_rsp_k, o_rsp_data, o_rsp_err);
        end
        n_checks++;
        if (o_rd_cnt !== 1 || o_wr_cnt !== 1 || sel_log[0] !== 4'd5 || o_both !== 1'b0) begin
            n_fail++;
            $display("FAIL copy_strobe: rd=%0d wr=%0d sel=%0d both=%b required 1 1 5 0",
                     o_rd_cnt, o_wr_cnt, sel_log[0], o_both);
        end
        run_cmd(2'b01, 4'd0, 4'd5, 32'h0);
        n_checks++;
        if (o_rsp_data !== 32'h0123_4567) begin
            n_fail++; $display("FAIL copy_readback: got %h required 01234567", o_rsp_data);
        end
        run_cmd(2'b00, 4'd2, 4'd0, 32'hcafe_0002);
        run_cmd(2'b10, 4'd2, 4'd2, 32'h0);
        run_cmd(2'b01, 4'd0, 4'd2, 32'h0);
        n_checks++;
        if (o_rsp_data !== 32'hcafe_0002) begin
            n_fail++; $display("FAIL copy_same_reg: got %h required cafe0002", o_rsp_data);
        end
    endtask

    task automatic test_clear();
        int bad_sel;
        run_cmd(2'b00, 4'd3, 4'd0, 32'hdead_beef);
        run_cmd(2'b11, 4'd0, 4'd0, 32'h0);
`ifdef REGFILE_MASTER_CLEAR_EN
        bad_sel = 0;
        for (int i = 0; i < 16; i++) if (sel_log[i] !== 4'(i)) bad_sel++;
        n_checks++;
        if (o_wr_cnt !== 16 || bad_sel !== 0) begin
            n_fail++;
            $display("FAIL clear_writes: pulses=%0d bad_sel=%0d required 16 0", o_wr_cnt, bad_sel);
        end
        n_checks++;
        if (o_rsp_k !== 17 || o_rsp_err !== 1'b0 || o_rsp_data !== 32'h0) begin
            n_fail++;
            $display("FAIL clear_rsp: k=%0d err=%b data=%h required 17 0 0",
                     o_rsp_k, o_rsp_err, o_rsp_data);
        end
        run_cmd(2'b01, 4'd0, 4'd3, 32'h0);
        n_checks++;
        if (o_rsp_data !== 32'h0) begin
            n_fail++; $display("FAIL clear_readback: got %h required 0", o_rsp_data);
        end
`else
        bad_sel = 0;
        n_checks++;
        if (o_en_cnt !== bad_sel) begin
            n_fail++; $display("FAIL clear_off_no_access: en pulses=%0d required 0", o_en_cnt);
        end
        n_checks++;
        if (o_rsp_k !== 1 || o_rsp_err !== 1'b1 || o_rsp_data !== 32'h0) begin
            n_fail++;
            $display("FAIL clear_off_rsp: k=%0d err=%b data=%h required 1 1 0",
                     o_rsp_k, o_rsp_err, o_rsp_data);
        end
        run_cmd(2'b01, 4'd0, 4'd3, 32'h0);
        n_checks++;
        if (o_rsp_data !== 32'hdead_beef || o_rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_off_readback: got %h err=%b required deadbeef 0",
                     o_rsp_data, o_rsp_err);
        end
`endif
    endtask

    task automatic test_reset_mid_copy();
        int wr_seen;
        int rsp_seen;
        run_cmd(2'b00, 4'd6, 4'd0, 32'h1111_6666);
        run_cmd(2'b00, 4'd7, 4'd0, 32'h7777_7777);
        while (!cmd_ready) @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_dst = 4'd7; cmd_src = 4'd6;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cmd_ready, rsp_valid, rf_en, rf_wr, rf_rd} !== 5'b0 || rf_ip !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: ready=%b rsp_v=%b en=%b ip=%h required all 0",
                     cmd_ready, rsp_valid, rf_en, rf_ip);
        end
        wr_seen = 0; rsp_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rf_en && rf_wr) wr_seen++;
            if (rsp_valid) rsp_seen++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rf_en && rf_wr) wr_seen++;
            if (rsp_valid) rsp_seen++;
            if (k == 0) begin
                n_checks++;
                if (cmd_ready !== 1'b1) begin
                    n_fail++; $display("FAIL midreset_ready: got %b required 1", cmd_ready);
                end
            end
        end
        n_checks++;
        if (wr_seen !== 0 || rsp_seen !== 0) begin
            n_fail++;
            $display("FAIL midreset_aborted: writes=%0d rsp=%0d required 0 0", wr_seen, rsp_seen);
        end
        run_cmd(2'b01, 4'd0, 4'd7, 32'h0);
        n_checks++;
        if (o_rsp_data !== 32'h7777_7777) begin
            n_fail++; $display("FAIL midreset_r7_kept: got %h required 77777777", o_rsp_data);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_dst = 4'd0; cmd_src = 4'd0; cmd_data = 32'h0;
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) sel_log[i] = 4'hx;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_copy();
        test_clear();
        test_reset_mid_copy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_master.md
# regfile_master

Command-driven initiator for the 16×32 register file. It accepts one upstream command at a time over a valid/ready handshake and converts it into the register file's EN/WR/RD/select/data strobes. It returns a single-cycle response carrying read data. It sits between a control source (sequencer, bus bridge or testbench) and the `registerfile` instance, and is the only driver of that register file's input ports.

## Interface
- No parameters. Data width is fixed at 32 bits and the register file depth at 16.
- `clk`  in  1  rising-edge clock, shared with the register file
- `rst_n`  in  1  asynchronous reset, active-low
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block can accept a command
- `cmd_op`  in  2  00 WRITE, 01 READ, 10 COPY, 11 CLEAR
- `cmd_dst`  in  4  destination register index
- `cmd_src`  in  4  source register index
- `cmd_data`  in  32  WRITE data
- `rsp_valid`  out  1  one-cycle response pulse
- `rsp_data`  out  32  READ data; 0 for other ops
- `rsp_err`  out  1  command was illegal
- `rf_ip`, `rf_sel_i`, `rf_sel_o1`, `rf_sel_o2`  out  32/4/4/4  drive register file `Ip1`, `sel_i1`, `sel_o1`, `sel_o2`
- `rf_wr`, `rf_rd`, `rf_en`  out  1 each  drive register file `WR`, `RD`, `EN`
- `rf_op1`  in  32  register file `Op1`
- `rf_op2`  in  32  register file `Op2`; unused, reserved

## Operation
- Register file contract:
  - A write happens at a rising edge with EN=1, WR=1.
  - A read with EN=1, RD=1 presents `Op1`/`Op2` registered: valid in the cycle after the edge that sampled RD.
- States: IDLE, WR, RD, CAP, CPWR, CLR, RSP.
- IDLE: `cmd_ready`=1. A command is accepted on an edge where `cmd_valid`&`cmd_ready`=1. The command fields are latched at that edge.
- Transitions out of IDLE:
  - WRITE → WR
  - READ → RD
  - COPY → RD
  - CLEAR → CLR, or RSP with error (see Configuration)
- WR:
  - Drives `rf_en`=1, `rf_wr`=1, `rf_sel_i`=dst, `rf_ip`=data for one cycle.
  - → RSP.
- RD:
  - Drives `rf_en`=1, `rf_rd`=1, `rf_sel_o1`=src, `rf_sel_o2`=src for one cycle.
  - → CAP.
- CAP: latches `rf_op1` into an internal buffer.
  - READ → RSP with `rsp_data`=buffer.
  - COPY → CPWR.
- CPWR:
  - Drives a write of the buffer to dst, same strobes as WR.
  - → RSP with `rsp_data`=0.
- CLR:
  - A 4-bit counter runs 0..15. Each cycle writes 32'h0 to register index=counter.
  - After index 15 → RSP. The counter resets to 0 on entry.
- RSP: `rsp_valid`=1 for exactly one cycle, then → IDLE. There is no response backpressure.
- Strobe rules:
  - `rf_wr` and `rf_rd` are never both 1.
  - `rf_en`=0 in IDLE, CAP and RSP.
  - Selects and `rf_ip` hold their last value when not strobing.
- COPY with src==dst performs the read and the write normally; register contents are unchanged.

## Timing
- All outputs are registered.
- Reset values: `cmd_ready`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_data`=0, all `rf_*` outputs=0, state IDLE, counter 0. `cmd_ready` rises on the first rising edge after `rst_n` deasserts.
- Command accepted at edge N. `cmd_ready` is 0 from edge N until the edge after the RSP cycle.
- WRITE: strobe cycle N+1, `rsp_valid` in cycle N+2.
- READ: strobe N+1, capture N+2, `rsp_valid` N+3.
- COPY: read strobe N+1, capture N+2, write strobe N+3, `rsp_valid` N+4.
- CLEAR: writes in cycles N+1..N+16, `rsp_valid` N+17.
- Next command: earliest acceptance is the edge ending the cycle after the RSP cycle.
- Reset mid-operation:
  - Immediately forces the reset values and aborts the command.
  - No response is issued.
  - A register write already sampled by the register file is not undone.
- `cmd_valid` while `cmd_ready`=0 is ignored. Upstream holds it until accepted.

## Configuration
- `REGFILE_MASTER_CLEAR_EN` defined: CLEAR behaves as described, with 16 writes and then a response with `rsp_err`=0.
- Not defined:
  - CLR state and counter are absent.
  - `cmd_op`=11 is accepted and performs no register file access.
  - RSP follows in cycle N+1 with `rsp_err`=1 and `rsp_data`=0.
- `rsp_err` is 0 for every other op in both builds.

## Test plan
- Reset: hold `rst_n`=0 for 5 cycles, release → all outputs 0, then `cmd_ready`=1 one edge after release.
- WRITE dst=0 data=32'habcd_efab, then READ src=0 → READ `rsp_data`=32'habcd_efab exactly 3 cycles after accept; `rf_wr` high for exactly one cycle.
- WRITE r1=32'h0123_4567, COPY src=1 dst=5, READ src=5 → 32'h0123_4567; COPY `rsp_valid` at N+4.
- CLEAR (macro on) after writing r3=32'hdead_beef → 16 `rf_wr` pulses with sel 0..15 in order, `rsp_valid` at N+17, then READ r3 returns 0.
- CLEAR with macro off → no `rf_en` pulse, `rsp_valid` with `rsp_err`=1 at N+1.
- Assert `rst_n`=0 during the COPY capture cycle → no CPWR write, no `rsp_valid`; `cmd_ready`=1 one edge after release.
